// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port: mem_ctrl op codes,
// FSM state encoding and size/alignment helpers.
package lsu_pkg;

    localparam logic [3:0] MEMOP_LD  = 4'b0000;
    localparam logic [3:0] MEMOP_LHU = 4'b0001;
    localparam logic [3:0] MEMOP_LBU = 4'b0010;
    localparam logic [3:0] MEMOP_LW  = 4'b0011;
    localparam logic [3:0] MEMOP_LH  = 4'b0100;
    localparam logic [3:0] MEMOP_LB  = 4'b0101;
    localparam logic [3:0] MEMOP_LWU = 4'b0110;
    localparam logic [3:0] MEMOP_SD  = 4'b1000;
    localparam logic [3:0] MEMOP_SW  = 4'b1001;
    localparam logic [3:0] MEMOP_SH  = 4'b1010;
    localparam logic [3:0] MEMOP_SB  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Access size in bytes; 0 marks an encoding that is not a real op.
    function automatic logic [3:0] op_size(input logic [3:0] ctrl);
        case (ctrl)
            MEMOP_LD, MEMOP_SD:             op_size = 4'd8;
            MEMOP_LW, MEMOP_LWU, MEMOP_SW:  op_size = 4'd4;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH:  op_size = 4'd2;
            MEMOP_LB, MEMOP_LBU, MEMOP_SB:  op_size = 4'd1;
            default:                        op_size = 4'd0;
        endcase
    endfunction

    // Invalid encodings are folded into the misaligned path so they never reach the bus.
    function automatic logic op_misaligned(input logic [3:0] ctrl, input logic [2:0] off);
        case (op_size(ctrl))
            4'd8:    op_misaligned = (off != 3'd0);
            4'd4:    op_misaligned = (off[1:0] != 2'd0);
            4'd2:    op_misaligned = off[0];
            4'd1:    op_misaligned = 1'b0;
            default: op_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: places store data and its byte mask on the
// 64-bit bus lanes, and extracts/extends load data from an aligned bus word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      mem_ctrl,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] bus_rdata,
    output logic [XLEN-1:0] lane_wdata,
    output logic [7:0]      lane_mask,
    output logic [XLEN-1:0] load_data
);

    logic [5:0]      bit_off;
    logic [XLEN-1:0] shifted;

    assign bit_off    = {offset, 3'b000};
    assign lane_wdata = wdata << bit_off;
    assign shifted    = bus_rdata >> bit_off;

    // Byte enables for stores; loads never write.
    always_comb begin
        lane_mask = 8'h00;
        case (mem_ctrl)
            MEMOP_SD: lane_mask = 8'hFF;
            MEMOP_SW: lane_mask = 8'h0F << offset;
            MEMOP_SH: lane_mask = 8'h03 << offset;
            MEMOP_SB: lane_mask = 8'h01 << offset;
            default:  lane_mask = 8'h00;
        endcase
    end

    // Sign- or zero-extend the selected bytes of the shifted load word.
    always_comb begin
        load_data = '0;
        case (mem_ctrl)
            MEMOP_LD:  load_data = shifted;
            MEMOP_LW:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            MEMOP_LWU: load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            MEMOP_LH:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEMOP_LHU: load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            MEMOP_LB:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MEMOP_LBU: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            default:   load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Memory-side responder for core load/store ops. Converts one request into a
// single aligned bus transaction, stalls the core until it completes and
// returns extended load data. Optional bus timeout: define LSU_TIMEOUT_EN.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [3:0]      mem_ctrl,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            req_ready,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rdata,
    output logic            misalign,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [7:0]      bus_wmask,
    input  logic            bus_rsp_valid,
    input  logic [XLEN-1:0] bus_rdata
);

    lsu_state_e      state;
    logic            ready_q;
    logic            mis_q;
    logic [3:0]      ctrl_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] load_data;
    logic [7:0]      lane_mask;
    logic            accept;
    logic            misalign_in;

`ifdef LSU_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic [15:0] unused_tmo;
    assign unused_tmo = 16'(TIMEOUT_CYCLES);
`endif

    // ready_q is held low through reset so every output reads 0 until the first clock.
    assign accept      = (state == ST_IDLE) && ready_q && req_valid;
    assign misalign_in = op_misaligned(mem_ctrl, addr[2:0]);

    assign req_ready     = ready_q;
    assign stall         = accept || (state == ST_REQ) || (state == ST_WAIT);
    assign rsp_valid     = (state == ST_RESP);
    assign misalign      = mis_q;
    assign rdata         = rdata_q;
    assign bus_req_valid = (state == ST_REQ);
    assign bus_we        = ctrl_q[3];
    assign bus_addr      = {addr_q[XLEN-1:3], 3'b000};
    assign bus_wdata     = lane_wdata;
    assign bus_wmask     = lane_mask;

    lsu_align #(.XLEN(XLEN)) u_align (
        .mem_ctrl   (ctrl_q),
        .offset     (addr_q[2:0]),
        .wdata      (wdata_q),
        .bus_rdata  (bus_rdata),
        .lane_wdata (lane_wdata),
        .lane_mask  (lane_mask),
        .load_data  (load_data)
    );

    // Request FSM: capture, bus handshake, wait for response, one-cycle completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
            mis_q   <= 1'b0;
            ctrl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= !accept;
                    if (accept) begin
                        ctrl_q  <= mem_ctrl;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rdata_q <= '0;
                        mis_q   <= misalign_in;
                        state   <= misalign_in ? ST_RESP : ST_REQ;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        state <= ST_WAIT;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        state   <= ST_RESP;
                        mis_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus_rsp_valid) begin
                        rdata_q <= ctrl_q[3] ? '0 : load_data;
                        state   <= ST_RESP;
`ifdef LSU_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state   <= ST_RESP;
                        mis_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mis_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed testbench for lsu_mem_port: table of single ops with hand-computed
// bus and response values, plus sequences for bus back-pressure, async reset
// mid-transaction, late responses and (with LSU_TIMEOUT_EN) the bus timeout.
module tb_lsu_mem_port;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  mem_ctrl;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [63:0] rdata;
    logic        misalign;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_rsp_valid;
    logic [63:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_port #(.XLEN(64), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .mem_ctrl      (mem_ctrl),
        .addr          (addr),
        .wdata         (wdata),
        .req_ready     (req_ready),
        .stall         (stall),
        .rsp_valid     (rsp_valid),
        .rdata         (rdata),
        .misalign      (misalign),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wmask     (bus_wmask),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] brdata;
        logic        mis;
        logic        we;
        logic [63:0] baddr;
        logic [63:0] bwdata;
        logic [7:0]  mask;
        logic [63:0] rd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, ".ready_wait"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        wait_ready(p);
        req_valid     = 1'b1;
        mem_ctrl      = v.ctrl;
        addr          = v.addr;
        wdata         = v.wdata;
        bus_req_ready = 1'b1;
        #1;
        check({p, ".stall_accept"}, {63'd0, stall}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.mis) begin
            check({p, ".rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
            check({p, ".misalign"}, {63'd0, misalign}, 64'd1);
            check({p, ".no_bus"}, {63'd0, bus_req_valid}, 64'd0);
            check({p, ".stall"}, {63'd0, stall}, 64'd0);
            check({p, ".rdata"}, rdata, 64'd0);
        end else begin
            check({p, ".bus_req_valid"}, {63'd0, bus_req_valid}, 64'd1);
            check({p, ".bus_we"}, {63'd0, bus_we}, {63'd0, v.we});
            check({p, ".bus_addr"}, bus_addr, v.baddr);
            check({p, ".bus_wmask"}, {56'd0, bus_wmask}, {56'd0, v.mask});
            if (v.we) check({p, ".bus_wdata"}, bus_wdata, v.bwdata);
            @(negedge clk);
            bus_req_ready = 1'b0;
            check({p, ".wait_no_req"}, {63'd0, bus_req_valid}, 64'd0);
            check({p, ".wait_stall"}, {63'd0, stall}, 64'd1);
            check({p, ".wait_no_rsp"}, {63'd0, rsp_valid}, 64'd0);
            bus_rsp_valid = 1'b1;
            bus_rdata     = v.brdata;
            @(negedge clk);
            bus_rsp_valid = 1'b0;
            check({p, ".rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
            check({p, ".misalign"}, {63'd0, misalign}, 64'd0);
            check({p, ".rdata"}, rdata, v.rd);
            check({p, ".stall"}, {63'd0, stall}, 64'd0);
        end
        bus_req_ready = 1'b0;
        @(negedge clk);
        check({p, ".rsp_pulse"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        ctrl     addr                    wdata                   bus_rdata               mis  we   bus_addr                bus_wdata               mask   rdata
        vecs[0]  = '{4'b0011, 64'h0000_0000_8000_0004, 64'h0,                  64'h8000_0001_1234_5678, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0,                  8'h00, 64'hFFFF_FFFF_8000_0001};
        vecs[1]  = '{4'b0010, 64'h0000_0000_8000_0003, 64'h0,                  64'h0000_0000_F000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0,                  8'h00, 64'h0000_0000_0000_00F0};
        vecs[2]  = '{4'b0101, 64'h0000_0000_8000_0003, 64'h0,                  64'h0000_0000_F000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_FFF0};
        vecs[3]  = '{4'b1010, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_ABCD, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0};
        vecs[4]  = '{4'b1001, 64'h0000_0000_8000_0002, 64'h1234,               64'h0,                  1'b1, 1'b0, 64'h0,                  64'h0,                  8'h00, 64'h0};
        vecs[5]  = '{4'b0000, 64'h0000_0000_8000_0008, 64'h0,                  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'h0000_0000_8000_0008, 64'h0,                  8'h00, 64'h0123_4567_89AB_CDEF};
        vecs[6]  = '{4'b0001, 64'h0000_0000_0000_1002, 64'h0,                  64'h0000_0000_8765_0000, 1'b0, 1'b0, 64'h0000_0000_0000_1000, 64'h0,                  8'h00, 64'h0000_0000_0000_8765};
        vecs[7]  = '{4'b0100, 64'h0000_0000_0000_1002, 64'h0,                  64'h0000_0000_8765_0000, 1'b0, 1'b0, 64'h0000_0000_0000_1000, 64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_8765};
        vecs[8]  = '{4'b0110, 64'h0000_0000_0000_1004, 64'h0,                  64'h8000_0001_1234_5678, 1'b0, 1'b0, 64'h0000_0000_0000_1000, 64'h0,                  8'h00, 64'h0000_0000_8000_0001};
        vecs[9]  = '{4'b1000, 64'h0000_0000_0000_2000, 64'h1122_3344_5566_7788, 64'h0,                  1'b0, 1'b1, 64'h0000_0000_0000_2000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0};
        vecs[10] = '{4'b1011, 64'h0000_0000_0000_2007, 64'h0000_0000_0000_005A, 64'h0,                  1'b0, 1'b1, 64'h0000_0000_0000_2000, 64'h5A00_0000_0000_0000, 8'h80, 64'h0};
        vecs[11] = '{4'b1001, 64'h0000_0000_0000_2004, 64'h0000_0000_CAFE_BABE, 64'h0,                  1'b0, 1'b1, 64'h0000_0000_0000_2000, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'h0};
        vecs[12] = '{4'b0111, 64'h0000_0000_0000_0000, 64'h0,                  64'h0,                  1'b1, 1'b0, 64'h0,                  64'h0,                  8'h00, 64'h0};
        vecs[13] = '{4'b1100, 64'h0000_0000_0000_0000, 64'h0,                  64'h0,                  1'b1, 1'b0, 64'h0,                  64'h0,                  8'h00, 64'h0};
        vecs[14] = '{4'b0000, 64'h0000_0000_0000_0004, 64'h0,                  64'h0,                  1'b1, 1'b0, 64'h0,                  64'h0,                  8'h00, 64'h0};
        vecs[15] = '{4'b0100, 64'h0000_0000_0000_1001, 64'h0,                  64'h0,                  1'b1, 1'b0, 64'h0,                  64'h0,                  8'h00, 64'h0};
        vecs[16] = '{4'b0101, 64'h0000_0000_0000_3007, 64'h0,                  64'h7F00_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_0000_3000, 64'h0,                  8'h00, 64'h0000_0000_0000_007F};

        rst_n         = 1'b0;
        req_valid     = 1'b0;
        mem_ctrl      = 4'd0;
        addr          = 64'd0;
        wdata         = 64'd0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 64'd0;

        // Reset state
        @(negedge clk);
        check("rst.req_ready", {63'd0, req_ready}, 64'd0);
        check("rst.stall", {63'd0, stall}, 64'd0);
        check("rst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst.misalign", {63'd0, misalign}, 64'd0);
        check("rst.bus_req_valid", {63'd0, bus_req_valid}, 64'd0);
        check("rst.bus_we", {63'd0, bus_we}, 64'd0);
        check("rst.bus_addr", bus_addr, 64'd0);
        check("rst.bus_wdata", bus_wdata, 64'd0);
        check("rst.bus_wmask", {56'd0, bus_wmask}, 64'd0);
        check("rst.rdata", rdata, 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst.req_ready", {63'd0, req_ready}, 64'd1);

        // Table-driven single ops with zero-wait bus
        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Back-pressure, busy request ignored, async reset in WAIT, late response
        wait_ready("bp");
        req_valid = 1'b1;
        mem_ctrl  = 4'b1000;
        addr      = 64'h0000_0000_0000_3008;
        wdata     = 64'h0102_0304_0506_0708;
        @(negedge clk);
        mem_ctrl = 4'b0011;
        addr     = 64'h0000_0000_0000_0040;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d.bus_req_valid", i), {63'd0, bus_req_valid}, 64'd1);
            check($sformatf("bp%0d.bus_addr", i), bus_addr, 64'h0000_0000_0000_3008);
            check($sformatf("bp%0d.bus_wmask", i), {56'd0, bus_wmask}, 64'hFF);
            check($sformatf("bp%0d.bus_wdata", i), bus_wdata, 64'h0102_0304_0506_0708);
            check($sformatf("bp%0d.req_ready", i), {63'd0, req_ready}, 64'd0);
            check($sformatf("bp%0d.stall", i), {63'd0, stall}, 64'd1);
            if (i < 4) @(negedge clk);
        end
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        check("bp.wait_no_req", {63'd0, bus_req_valid}, 64'd0);
        check("bp.wait_stall", {63'd0, stall}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.stall", {63'd0, stall}, 64'd0);
        check("arst.req_ready", {63'd0, req_ready}, 64'd0);
        check("arst.bus_we", {63'd0, bus_we}, 64'd0);
        check("arst.bus_addr", bus_addr, 64'd0);
        check("arst.bus_wmask", {56'd0, bus_wmask}, 64'd0);
        check("arst.bus_wdata", bus_wdata, 64'd0);
        check("arst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus_rsp_valid = 1'b1;
        bus_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        check("late.rsp_valid0", {63'd0, rsp_valid}, 64'd0);
        check("late.req_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        check("late.rsp_valid1", {63'd0, rsp_valid}, 64'd0);
        check("late.rdata", rdata, 64'd0);

        // Normal op still works after the aborted transaction
        run_vec(vecs[0], 100);

`ifdef LSU_TIMEOUT_EN
        // Bus accepts but never responds: timeout after TMO WAIT cycles
        wait_ready("tmo");
        req_valid     = 1'b1;
        mem_ctrl      = 4'b0000;
        addr          = 64'h0000_0000_0000_4000;
        bus_req_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("tmo.bus_req_valid", {63'd0, bus_req_valid}, 64'd1);
        @(negedge clk);
        bus_req_ready = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            check($sformatf("tmo.wait%0d.rsp_valid", i), {63'd0, rsp_valid}, 64'd0);
            check($sformatf("tmo.wait%0d.stall", i), {63'd0, stall}, 64'd1);
            @(negedge clk);
        end
        check("tmo.rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("tmo.misalign", {63'd0, misalign}, 64'd1);
        check("tmo.rdata", rdata, 64'd0);
        check("tmo.stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        check("tmo.rsp_pulse", {63'd0, rsp_valid}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
